seg_display_ctrl: RTL and testbench

- Parametrised N-digit seven-segment display controller; successor to the fixed two-channel combinational hex decoder.
- Holds a double-buffered display image (hex nibbles, enable/blink/dp masks) loaded over a valid/ready write port; updates are applied only at frame boundaries, so the display never tears.
- Drives both per-digit static segment outputs (FPGA board segs) and a time-multiplexed scan interface (shared segment bus plus active-low digit selects).
- Adds leading-zero suppression, per-digit blink and decimal points.

---
 rtl/seg_display_ctrl.sv | 157 +++++++++++++++
 tb/tb_seg_display_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/seg_display_ctrl.sv
// N-digit seven-segment controller: double-buffered image, static + multiplexed scan outputs.
// Latency: all display outputs are registered one cycle after the image/scan state they show.
// Backpressure: wr_ready drops while an image is pending and rises the cycle after it loads at frame end.
module seg_display_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [4*NUM_DIGITS-1:0]   wr_value,
  input  logic [NUM_DIGITS-1:0]     wr_en_mask,
  input  logic [NUM_DIGITS-1:0]     wr_blink_mask,
  input  logic [NUM_DIGITS-1:0]     wr_dp_mask,
  input  logic                      lzs_en,
  output logic [8*NUM_DIGITS-1:0]   seg_static,
  output logic [7:0]                scan_seg,
  output logic [NUM_DIGITS-1:0]     scan_an,
  output logic                      frame_tick
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   en;
    logic [NUM_DIGITS-1:0]   blink;
    logic [NUM_DIGITS-1:0]   dp;
  } image_t;

  image_t                   wr_img;
  image_t                   active_img;
  image_t                   pending_img;
  logic                     pending;

  logic [CW-1:0]            scan_cnt;
  logic [IW-1:0]            scan_idx;
  logic [BW-1:0]            blink_cnt;
  logic                     blink_hidden;

  logic                     slot_tick;
  logic                     frame_end;
  logic [NUM_DIGITS-1:0]    suppressed;
  logic [7:0]               digit_code [NUM_DIGITS];
  logic [8*NUM_DIGITS-1:0]  static_next;
  logic [NUM_DIGITS-1:0]    an_next;

  // Glyph bits a..g,dp before the active-low inversion; dp is merged separately.
  function automatic logic [7:0] glyph(input logic [3:0] nib);
    logic [7:0] g;
    case (nib)
      4'h0: g = 8'hFC;
      4'h1: g = 8'h60;
      4'h2: g = 8'hDA;
      4'h3: g = 8'hF2;
      4'h4: g = 8'h66;
      4'h5: g = 8'hB6;
      4'h6: g = 8'hBE;
      4'h7: g = 8'hE0;
      4'h8: g = 8'hFE;
      4'h9: g = 8'hF6;
      4'hA: g = 8'hEE;
      4'hB: g = 8'h3E;
      4'hC: g = 8'h9C;
      4'hD: g = 8'h7A;
      4'hE: g = 8'h9E;
      default: g = 8'h8E;
    endcase
    return g;
  endfunction

  assign wr_img = '{value: wr_value, en: wr_en_mask, blink: wr_blink_mask, dp: wr_dp_mask};

  assign wr_ready  = !pending;
  assign slot_tick = (scan_cnt == CNT_LAST);
  assign frame_end = slot_tick && (scan_idx == IDX_LAST);

  // A digit is suppressed while every nibble from the top down to it is zero; digit 0 never is.
  always_comb begin
    logic zero_run;
    zero_run   = lzs_en;
    suppressed = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run      = zero_run && (active_img.value[4*i +: 4] == 4'h0);
      suppressed[i] = zero_run;
    end
  end

  always_comb begin
    static_next = '1;
    an_next     = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!active_img.en[i] || (blink_hidden && active_img.blink[i]) || suppressed[i]) begin
        digit_code[i] = 8'hFF;
      end else begin
        digit_code[i] = ~(glyph(active_img.value[4*i +: 4]) | {7'b0, active_img.dp[i]});
      end
      static_next[8*i +: 8] = digit_code[i];
      // First cycle of every slot keeps all digits off so the bus can settle without ghosting.
      an_next[i] = (scan_cnt == '0) || (scan_idx != IW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_img   <= '0;
      pending_img  <= '0;
      pending      <= 1'b0;
      scan_cnt     <= '0;
      scan_idx     <= '0;
      blink_cnt    <= '0;
      blink_hidden <= 1'b0;
      seg_static   <= '1;
      scan_seg     <= 8'hFF;
      scan_an      <= '1;
      frame_tick   <= 1'b0;
    end else begin
      scan_cnt <= slot_tick ? '0 : scan_cnt + CW'(1);

      if (slot_tick) begin
        scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IW'(1);
      end

      if (frame_end) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt    <= '0;
          blink_hidden <= !blink_hidden;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end

      // Image swap only at frame end; a write landing in that same cycle waits a full frame.
      if (frame_end && pending) begin
        active_img <= pending_img;
        pending    <= 1'b0;
      end else if (wr_valid && !pending) begin
        pending_img <= wr_img;
        pending     <= 1'b1;
      end

      seg_static <= static_next;
      scan_seg   <= digit_code[scan_idx];
      scan_an    <= an_next;
      frame_tick <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Randomized bench for seg_display_ctrl against a transaction-level display model.
module tb_seg_display_ctrl;

  localparam int N  = 4;
  localparam int SD = 4;
  localparam int BF = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic          wr_ready;
  logic [15:0]   wr_value;
  logic [3:0]    wr_en_mask;
  logic [3:0]    wr_blink_mask;
  logic [3:0]    wr_dp_mask;
  logic          lzs_en;
  logic [31:0]   seg_static;
  logic [7:0]    scan_seg;
  logic [3:0]    scan_an;
  logic          frame_tick;

  always #5 clk = ~clk;

  seg_display_ctrl #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_value(wr_value), .wr_en_mask(wr_en_mask),
    .wr_blink_mask(wr_blink_mask), .wr_dp_mask(wr_dp_mask),
    .lzs_en(lzs_en),
    .seg_static(seg_static), .scan_seg(scan_seg),
    .scan_an(scan_an), .frame_tick(frame_tick)
  );

  logic [7:0] glyph_tbl [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                 8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

  // Model state: displayed image, buffered image, cycles since reset release.
  logic [15:0] m_val, p_val;
  logic [3:0]  m_en, m_blk, m_dp, p_en, p_blk, p_dp;
  bit          m_pend;
  bit          m_init = 0;
  int          cyc;
  int          sc, idx, frames;
  bit          hidden, acc;

  logic [31:0] exp_seg;
  logic [7:0]  exp_scan;
  logic [3:0]  exp_an;
  logic        exp_tick;

  int n_chk  = 0;
  int n_pass = 0;

  function automatic logic [7:0] exp_digit(input int i, input logic [15:0] v,
                                           input logic [3:0] en, input logic [3:0] blk,
                                           input logic [3:0] dp, input bit hid, input bit lzs);
    int top = -1;
    for (int j = 0; j < N; j++) if (v[4*j +: 4] != 4'h0) top = j;
    if (!en[i]) return 8'hFF;
    if (hid && blk[i]) return 8'hFF;
    if (lzs && i > top && i != 0) return 8'hFF;
    return ~(glyph_tbl[v[4*i +: 4]] | (dp[i] ? 8'h01 : 8'h00));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      cyc = 0; m_pend = 0;
      m_val = '0; m_en = '0; m_blk = '0; m_dp = '0;
      p_val = '0; p_en = '0; p_blk = '0; p_dp = '0;
      exp_seg = '1; exp_scan = 8'hFF; exp_an = '1; exp_tick = 1'b0;
      m_init = 1;
    end else begin
      sc     = cyc % SD;
      idx    = (cyc / SD) % N;
      frames = cyc / (N * SD);
      hidden = ((frames / BF) % 2) == 1;
      for (int i = 0; i < N; i++)
        exp_seg[8*i +: 8] = exp_digit(i, m_val, m_en, m_blk, m_dp, hidden, lzs_en);
      exp_scan = exp_seg[8*idx +: 8];
      exp_an   = (sc == 0) ? 4'hF : ~(4'b0001 << idx);
      exp_tick = (sc == SD - 1) && (idx == N - 1);
      acc = wr_valid && !m_pend;
      if (exp_tick && m_pend) begin
        m_val = p_val; m_en = p_en; m_blk = p_blk; m_dp = p_dp;
        m_pend = 0;
      end
      if (acc) begin
        p_val = wr_value; p_en = wr_en_mask; p_blk = wr_blink_mask; p_dp = wr_dp_mask;
        m_pend = 1;
      end
      cyc++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic step();
    @(negedge clk);
    if (m_init) begin
      chk("seg_static", seg_static, exp_seg);
      chk("scan_an", scan_an, exp_an);
      if (exp_an != 4'hF) chk("scan_seg", scan_seg, exp_scan);
      chk("frame_tick", frame_tick, exp_tick);
      chk("wr_ready", wr_ready, !m_pend);
    end
  endtask

  task automatic drive_random();
    wr_valid = ($urandom_range(0, 2) == 0);
    for (int j = 0; j < N; j++)
      wr_value[4*j +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
    wr_en_mask    = 4'($urandom) | 4'($urandom);
    wr_blink_mask = 4'($urandom);
    wr_dp_mask    = 4'($urandom);
    if ($urandom_range(0, 31) == 0) lzs_en = !lzs_en;
  endtask

  task automatic write_img(input logic [15:0] v, input logic [3:0] en,
                           input logic [3:0] blk, input logic [3:0] dp);
    wr_valid = 1'b1; wr_value = v; wr_en_mask = en; wr_blink_mask = blk; wr_dp_mask = dp;
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_value = '0; lzs_en = 1'b0;
    wr_en_mask = '0; wr_blink_mask = '0; wr_dp_mask = '0;

    repeat (3) begin
      step();
      drive_random();
    end
    rst = 1'b0; wr_valid = 1'b0; lzs_en = 1'b0;

    // Frame-synchronous load of 1234 written in cycle 2.
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 1) chk("ready_after_rst", wr_ready, 1'b1);
      if (k == 3) chk("ready_drop", wr_ready, 1'b0);
      if (k == 16) chk("ready_rise", wr_ready, 1'b1);
      if (k == 17) chk("load_1234", seg_static, 32'h9F250D99);
      if (k == 2) write_img(16'h1234, 4'hF, 4'h0, 4'h0);
      else wr_valid = 1'b0;
    end

    // Leading-zero suppression on and off.
    write_img(16'h00A5, 4'hF, 4'h0, 4'h0);
    lzs_en = 1'b1;
    step();
    wr_valid = 1'b0;
    repeat (39) step();
    chk("lzs_on", seg_static, 32'hFFFF1149);
    lzs_en = 1'b0;
    step();
    chk("lzs_off", seg_static, 32'h03031149);

    // Blink on digit 0, decimal point on digit 1.
    write_img(16'h0087, 4'hF, 4'b0001, 4'b0010);
    step();
    wr_valid = 1'b0;
    repeat (200) step();

    // Reset mid-frame with a write still pending.
    write_img(16'h5555, 4'hF, 4'h0, 4'h0);
    step();
    wr_valid = 1'b0;
    repeat (2) step();
    chk("pending_before_rst", wr_ready, 1'b0);
    rst = 1'b1;
    step();
    chk("rst_mid_seg", seg_static, 32'hFFFFFFFF);
    chk("rst_mid_an", scan_an, 4'hF);
    chk("rst_mid_ready", wr_ready, 1'b1);
    rst = 1'b0;
    repeat (40) step();
    chk("pending_discarded", seg_static, 32'hFFFFFFFF);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 2500; k++) begin
      step();
      drive_random();
      rst = ($urandom_range(0, 499) == 0);
    end
    rst = 1'b0;
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
